q_retry_backoff_timer: RTL and testbench

//   Multi-channel Q-channel retry cooldown timer with optional exponential backoff.

---
 rtl/q_retry_backoff_timer.sv | 86 ++++++++
 tb/tb_q_retry_backoff_timer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/q_retry_backoff_timer.sv
// Per-channel Q-channel retry cooldown timer with optional exponential backoff.
// Each channel counts W = B or B<<level cycles from start, then pulses done; abort cancels silently.
module q_retry_backoff_timer #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 8,
  parameter int MAX_SHIFT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  base_wait,
  input  logic              backoff_en,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] abort,
  input  logic [NUM_CH-1:0] success,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] sat
);

  localparam int CW = CNT_W + MAX_SHIFT;
  localparam int LW = (MAX_SHIFT < 1) ? 1 : $clog2(MAX_SHIFT + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

  // A zero base period is treated as one cycle so a started channel always asserts busy.
  logic [CW-1:0] base_eff;
  assign base_eff = (base_wait == '0) ? CW'(1) : CW'(base_wait);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [LW-1:0] level;
    logic [LW-1:0] level_nxt;
    logic [CW-1:0] load_val;
    logic          terminal;
    logic          inc;
    logic          done_r;
    logic          sat_r;

    always_comb begin
      terminal  = (state == ST_COUNT) && (cnt == CW'(1));
      load_val  = backoff_en ? (base_eff << level) : base_eff;
      // Abort or restart on the terminal edge suppresses the completion, so no level step either.
      inc       = terminal && !abort[g] && !start[g] && backoff_en &&
                  (level < LW'(MAX_SHIFT));
      level_nxt = success[g] ? '0 : (inc ? level + LW'(1) : level);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        level  <= '0;
        done_r <= 1'b0;
        sat_r  <= 1'b0;
      end else begin
        level <= level_nxt;
        sat_r <= (level_nxt == LW'(MAX_SHIFT));
        if (abort[g]) begin
          state  <= ST_IDLE;
          cnt    <= '0;
          done_r <= 1'b0;
        end else if (start[g]) begin
          state  <= ST_COUNT;
          cnt    <= load_val;
          done_r <= 1'b0;
        end else if (terminal) begin
          state  <= ST_IDLE;
          cnt    <= '0;
          done_r <= 1'b1;
        end else if (state == ST_COUNT) begin
          cnt    <= cnt - CW'(1);
          done_r <= 1'b0;
        end else begin
          done_r <= 1'b0;
        end
      end
    end

    assign busy[g] = (state == ST_COUNT);
    assign done[g] = done_r;
    assign sat[g]  = sat_r;
  end

endmodule

// File: tb/tb_q_retry_backoff_timer.sv
// Bench for q_retry_backoff_timer: deadline-based reference model checked every cycle,
// plus directed scenarios with hand-computed busy widths and flag values.
module tb_q_retry_backoff_timer;

  localparam int NCH  = 4;
  localparam int MAXS = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     base_wait;
  logic           backoff_en;
  logic [NCH-1:0] start, abort, success;
  wire  [NCH-1:0] busy, done, sat;

  q_retry_backoff_timer #(.NUM_CH(NCH), .CNT_W(8), .MAX_SHIFT(MAXS)) dut (
    .clk(clk), .reset(reset), .base_wait(base_wait), .backoff_en(backoff_en),
    .start(start), .abort(abort), .success(success),
    .busy(busy), .done(done), .sat(sat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a started channel is busy until an absolute completion edge.
  int             edge_no = 0;
  int             m_level [NCH];
  int             m_deadline [NCH];
  bit             m_active [NCH];
  logic [NCH-1:0] e_busy = '0, e_done = '0, e_sat = '0;

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_level[i] = 0; m_deadline[i] = 0; m_active[i] = 0;
    end
  end

  always @(posedge clk) begin
    int b, w;
    edge_no++;
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        m_active[c] = 0; m_level[c] = 0; e_done[c] = 0;
      end else begin
        bit fin;
        fin = 0;
        b = (base_wait == 0) ? 1 : int'(base_wait);
        w = backoff_en ? b * (1 << m_level[c]) : b;
        if (abort[c]) m_active[c] = 0;
        else if (start[c]) begin
          m_active[c] = 1; m_deadline[c] = edge_no + w;
        end else if (m_active[c] && edge_no == m_deadline[c]) begin
          m_active[c] = 0; fin = 1;
        end
        if (success[c]) m_level[c] = 0;
        else if (fin && backoff_en && m_level[c] < MAXS) m_level[c]++;
        e_done[c] = fin;
      end
      e_busy[c] = m_active[c];
      e_sat[c]  = (m_level[c] == MAXS);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", int'(busy), int'(e_busy));
      check("model_done", int'(done), int'(e_done));
      check("model_sat",  int'(sat),  int'(e_sat));
    end
  end

  // Pulse start for one cycle; returns in the first busy cycle.
  task automatic pulse_start(input int ch);
    @(negedge clk); start[ch] = 1'b1;
    @(negedge clk); start[ch] = 1'b0;
  endtask

  // One full round: returns the measured busy width and the done value right after.
  task automatic round(input int ch, input int exp_w, input string name);
    int w;
    pulse_start(ch);
    w = 0;
    while (busy[ch] && w < 200) begin
      w++;
      @(negedge clk);
    end
    check({name, "_width"}, w, exp_w);
    check({name, "_done"}, int'(done[ch]), 1);
  endtask

  initial begin
    int w, dn;
    reset = 1'b1; base_wait = 8'd0; backoff_en = 1'b0;
    start = '0; abort = '0; success = '0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_sat",  int'(sat),  0);
    reset = 1'b0;

    // Fixed period; level frozen at 0 so backoff mode afterwards still gives B.
    base_wait = 8'd5;
    round(0, 5, "t1_r1");
    round(0, 5, "t1_r2");
    backoff_en = 1'b1;
    round(0, 5, "t1_bo");

    // Exponential backoff with saturation.
    base_wait = 8'd4;
    round(1, 4,  "t2_r1");
    round(1, 8,  "t2_r2");
    round(1, 16, "t2_r3");
    check("t2_sat_r3", int'(sat[1]), 1);
    round(1, 32, "t2_r4");
    round(1, 32, "t2_r5");

    // Success clears the level.
    @(negedge clk); success[1] = 1'b1;
    @(negedge clk); success[1] = 1'b0;
    check("t3_sat_clr", int'(sat[1]), 0);
    round(1, 4, "t3_r1");

    // Abort mid-count, and abort together with start.
    backoff_en = 1'b0;
    base_wait  = 8'd10;
    pulse_start(2);
    repeat (2) @(negedge clk);
    check("t4_busy_c3", int'(busy[2]), 1);
    abort[2] = 1'b1;
    @(negedge clk); abort[2] = 1'b0;
    check("t4_abort_busy", int'(busy[2]), 0);
    check("t4_abort_done", int'(done[2]), 0);
    @(negedge clk);
    check("t4_abort_done2", int'(done[2]), 0);
    start[2] = 1'b1; abort[2] = 1'b1;
    @(negedge clk); start[2] = 1'b0; abort[2] = 1'b0;
    check("t4_start_abort", int'(busy[2]), 0);

    // Restart in busy cycle 4 of a 6-cycle wait.
    base_wait = 8'd6;
    pulse_start(3);
    w = 0; dn = 0;
    while (busy[3] && w < 200) begin
      w++;
      dn += int'(done[3]);
      start[3] = (w == 4);
      @(negedge clk);
    end
    start[3] = 1'b0;
    dn += int'(done[3]);
    check("t5_restart_width", w, 10);
    check("t5_restart_dones", dn, 1);
    base_wait = 8'd0;
    round(3, 1, "t5_base0");

    // Staggered starts, reset mid-count.
    base_wait = 8'd20;
    for (int c = 0; c < NCH; c++) begin
      @(negedge clk); start = '0; start[c] = 1'b1;
    end
    @(negedge clk); start = '0;
    check("t6_all_busy", int'(busy), 15);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_done", int'(done), 0);
    check("t6_rst_sat",  int'(sat),  0);

    // Simultaneous starts on all channels complete together.
    base_wait = 8'd3;
    @(negedge clk); start = '1;
    @(negedge clk); start = '0;
    repeat (2) @(negedge clk);
    check("t6_sim_busy", int'(busy), 15);
    @(negedge clk);
    check("t6_sim_done", int'(done), 15);
    check("t6_sim_idle", int'(busy), 0);
    repeat (3) @(negedge clk);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
